multicycle_control_fsm: RTL and testbench

- Multicycle control unit for the 16-bit datapath: latches the 4-bit opcode, sequences fetch/decode/execute/memory/writeback, and drives every datapath control strobe.
- Sits directly upstream of the datapath top level. It consumes that level's `op` and `cmpRst`, and its outputs connect one-to-one to that level's control inputs.
- Also keeps retired-instruction and cycle counters, and a halt flag.

---
 rtl/multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the 16-bit datapath: latches the opcode, sequences
// fetch/decode/execute/memory/writeback and drives every datapath control strobe.
module multicycle_control_fsm #(
  parameter int unsigned COUNT_W = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [3:0]         op,
  input  logic [1:0]         cmpRst,
  output logic [1:0]         immShift,
  output logic [2:0]         ALUOp,
  output logic               writeEnable,
  output logic [1:0]         numBits,
  output logic               memAddrSel,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               memEnableRead,
  output logic               memEnableWrite,
  output logic               PCWriteEnable,
  output logic               PCSource,
  output logic [2:0]         regDataWrite,
  output logic               DOrS,
  output logic               IRWrite,
  output logic [3:0]         state,
  output logic               halted,
  output logic [COUNT_W-1:0] instret,
  output logic [COUNT_W-1:0] cycles
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_ALU  = 4'd2,
    S_EX_ADDR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_ALU_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_LOADI   = 4'd10,
    S_IN      = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_BLT  = 4'd13;

  state_t             state_q, state_d;
  logic [3:0]         opq;
  logic [COUNT_W-1:0] instret_q, cycles_q;

  logic [2:0] alu_op_c, reg_data_write_c;
  logic [1:0] num_bits_c;
  logic       write_enable_c, mem_addr_sel_c, alu_src_a_c, alu_src_b_c;
  logic       mem_read_c, mem_write_c, pc_write_c, pc_source_c;
  logic       d_or_s_c, ir_write_c, halted_c, taken_c;

  // State, latched opcode and counters; a reset cycle clears everything and is not counted.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opq       <= '0;
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_q + COUNT_W'(1);
      if (state_q == S_DECODE) opq <= op;
      if (state_q != S_FETCH && state_d == S_FETCH) instret_q <= instret_q + COUNT_W'(1);
    end
  end

  always_comb begin
    unique case (opq)
      OP_BEQ:  taken_c = (cmpRst == 2'b00);
      OP_BNE:  taken_c = (cmpRst != 2'b00);
      OP_BLT:  taken_c = (cmpRst == 2'b01);
      default: taken_c = 1'b0;
    endcase
  end

  // Next state and control decode from current state and latched opcode.
  always_comb begin
    state_d          = state_q;
    alu_op_c         = 3'd0;
    reg_data_write_c = 3'd0;
    num_bits_c       = 2'd0;
    write_enable_c   = 1'b0;
    mem_addr_sel_c   = 1'b0;
    alu_src_a_c      = 1'b0;
    alu_src_b_c      = 1'b0;
    mem_read_c       = 1'b0;
    mem_write_c      = 1'b0;
    pc_write_c       = 1'b0;
    pc_source_c      = 1'b0;
    d_or_s_c         = 1'b0;
    ir_write_c       = 1'b0;
    halted_c         = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 1'b1;
        num_bits_c  = 2'd1;
        if (op == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          case (op)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: state_d = S_EX_ALU;
            4'd8:                   state_d = S_LOADI;
            4'd9, 4'd10:            state_d = S_EX_ADDR;
            4'd11, 4'd12, 4'd13:    state_d = S_BRANCH;
            4'd14:                  state_d = S_JUMP;
            default:                state_d = S_HALT;
          endcase
        end
      end
      S_EX_ALU: begin
        alu_src_a_c = 1'b1;
        if (opq == OP_ADDI) begin
          alu_src_b_c = 1'b1;
        end else begin
          alu_op_c = opq[2:0];
        end
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        write_enable_c = 1'b1;
        state_d        = S_FETCH;
      end
      S_EX_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 1'b1;
        state_d     = (opq == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_addr_sel_c = 1'b1;
        mem_read_c     = 1'b1;
        state_d        = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_data_write_c = 3'd1;
        write_enable_c   = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WR: begin
        mem_addr_sel_c = 1'b1;
        mem_write_c    = 1'b1;
        d_or_s_c       = 1'b1;
        state_d        = S_FETCH;
      end
      S_LOADI: begin
        num_bits_c       = 2'd1;
        reg_data_write_c = 3'd2;
        write_enable_c   = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b_c = 1'b1;
        num_bits_c  = 2'd1;
        pc_source_c = 1'b1;
        pc_write_c  = taken_c;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        alu_src_b_c = 1'b1;
        num_bits_c  = 2'd2;
        pc_source_c = 1'b1;
        pc_write_c  = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output in its own cycle so an aborted instruction issues no write.
  assign immShift       = 2'd0;
  assign ALUOp          = reset ? 3'd0 : alu_op_c;
  assign writeEnable    = ~reset & write_enable_c;
  assign numBits        = reset ? 2'd0 : num_bits_c;
  assign memAddrSel     = ~reset & mem_addr_sel_c;
  assign ALUSrcA        = ~reset & alu_src_a_c;
  assign ALUSrcB        = ~reset & alu_src_b_c;
  assign memEnableRead  = ~reset & mem_read_c;
  assign memEnableWrite = ~reset & mem_write_c;
  assign PCWriteEnable  = ~reset & pc_write_c;
  assign PCSource       = ~reset & pc_source_c;
  assign regDataWrite   = reset ? 3'd0 : reg_data_write_c;
  assign DOrS           = ~reset & d_or_s_c;
  assign IRWrite        = ~reset & ir_write_c;
  assign halted         = ~reset & halted_c;
  assign state          = reset ? S_FETCH : state_q;
  assign instret        = reset ? '0 : instret_q;
  assign cycles         = reset ? '0 : cycles_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; a second 3-bit-counter instance checks wrap.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic [1:0] cmpRst;

  logic [1:0]  immShift, numBits;
  logic [2:0]  ALUOp, regDataWrite;
  logic        writeEnable, memAddrSel, ALUSrcA, ALUSrcB, memEnableRead, memEnableWrite;
  logic        PCWriteEnable, PCSource, DOrS, IRWrite, halted;
  logic [3:0]  state;
  logic [15:0] instret, cycles;

  logic [1:0] w_immShift, w_numBits;
  logic [2:0] w_ALUOp, w_regDataWrite;
  logic       w_writeEnable, w_memAddrSel, w_ALUSrcA, w_ALUSrcB, w_memEnableRead, w_memEnableWrite;
  logic       w_PCWriteEnable, w_PCSource, w_DOrS, w_IRWrite, w_halted;
  logic [3:0] w_state;
  logic [2:0] w_instret, w_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm u_dut (
    .CLK(clk), .reset(reset), .op(op), .cmpRst(cmpRst),
    .immShift(immShift), .ALUOp(ALUOp), .writeEnable(writeEnable), .numBits(numBits),
    .memAddrSel(memAddrSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .memEnableRead(memEnableRead), .memEnableWrite(memEnableWrite),
    .PCWriteEnable(PCWriteEnable), .PCSource(PCSource), .regDataWrite(regDataWrite),
    .DOrS(DOrS), .IRWrite(IRWrite), .state(state), .halted(halted),
    .instret(instret), .cycles(cycles)
  );

  multicycle_control_fsm #(.COUNT_W(3)) u_dut_w (
    .CLK(clk), .reset(reset), .op(op), .cmpRst(cmpRst),
    .immShift(w_immShift), .ALUOp(w_ALUOp), .writeEnable(w_writeEnable), .numBits(w_numBits),
    .memAddrSel(w_memAddrSel), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB),
    .memEnableRead(w_memEnableRead), .memEnableWrite(w_memEnableWrite),
    .PCWriteEnable(w_PCWriteEnable), .PCSource(w_PCSource), .regDataWrite(w_regDataWrite),
    .DOrS(w_DOrS), .IRWrite(w_IRWrite), .state(w_state), .halted(w_halted),
    .instret(w_instret), .cycles(w_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge; read and write never overlap.
  task automatic step();
    @(posedge clk);
    #1;
    chk("rd_wr_excl", 32'(memEnableRead & memEnableWrite), 0);
  endtask

  task automatic chk_ctr(input string tag, input int ir, input int cy);
    chk({tag, "_instret"}, 32'(instret), ir);
    chk({tag, "_cycles"}, 32'(cycles), cy);
  endtask

  // Runs a branch from FETCH: decode, branch (check PC write), back to FETCH.
  task automatic run_branch(input logic [3:0] o, input logic [1:0] c, input logic exp_taken,
                            input string tag);
    op = o; cmpRst = c;
    step();
    step();
    chk({tag, "_state"}, 32'(state), 8);
    chk({tag, "_pcwe"}, 32'(PCWriteEnable), 32'(exp_taken));
    chk({tag, "_pcsrc"}, 32'(PCSource), 1);
    step();
  endtask

  initial begin
    reset = 1'b1; op = 4'd0; cmpRst = 2'b00;
    repeat (3) begin
      step();
      chk("rst_state", 32'(state), 0);
      chk("rst_memrd", 32'(memEnableRead), 0);
      chk("rst_irwrite", 32'(IRWrite), 0);
      chk("rst_pcwe", 32'(PCWriteEnable), 0);
      chk("rst_halted", 32'(halted), 0);
      chk_ctr("rst", 0, 0);
    end
    reset = 1'b0;
    #1;
    chk("fetch_state", 32'(state), 0);
    chk("fetch_irwrite", 32'(IRWrite), 1);
    chk("fetch_pcwe", 32'(PCWriteEnable), 1);
    chk("fetch_memrd", 32'(memEnableRead), 1);
    chk("fetch_pcsrc", 32'(PCSource), 0);
    chk_ctr("fetch", 0, 0);

    // SUB
    op = 4'd1;
    step();
    chk("sub_dec_state", 32'(state), 1);
    chk("sub_dec_srcb", 32'(ALUSrcB), 1);
    chk("sub_dec_nbits", 32'(numBits), 1);
    step();
    chk("sub_ex_state", 32'(state), 2);
    chk("sub_ex_aluop", 32'(ALUOp), 1);
    chk("sub_ex_srca", 32'(ALUSrcA), 1);
    chk("sub_ex_srcb", 32'(ALUSrcB), 0);
    step();
    chk("sub_wb_state", 32'(state), 6);
    chk("sub_wb_we", 32'(writeEnable), 1);
    chk("sub_wb_rdw", 32'(regDataWrite), 0);
    chk("sub_wb_instret", 32'(instret), 0);
    step();
    chk("sub_end_state", 32'(state), 0);
    chk_ctr("sub_end", 1, 4);
    chk("w_sub_cycles", 32'(w_cycles), 4);

    // LW
    op = 4'd9;
    step();
    step();
    chk("lw_exaddr_state", 32'(state), 3);
    chk("lw_exaddr_srcb", 32'(ALUSrcB), 1);
    chk("lw_exaddr_nbits", 32'(numBits), 0);
    step();
    chk("lw_memrd_state", 32'(state), 4);
    chk("lw_memrd_sel", 32'(memAddrSel), 1);
    chk("lw_memrd_rd", 32'(memEnableRead), 1);
    step();
    chk("lw_memwb_state", 32'(state), 5);
    chk("lw_memwb_rdw", 32'(regDataWrite), 1);
    chk("lw_memwb_we", 32'(writeEnable), 1);
    step();
    chk_ctr("lw_end", 2, 9);
    chk("w_lw_cycles", 32'(w_cycles), 1);

    // SW
    op = 4'd10;
    step();
    step();
    step();
    chk("sw_memwr_state", 32'(state), 7);
    chk("sw_memwr_wr", 32'(memEnableWrite), 1);
    chk("sw_memwr_dors", 32'(DOrS), 1);
    chk("sw_memwr_we", 32'(writeEnable), 0);
    step();
    chk("sw_after_wr", 32'(memEnableWrite), 0);
    chk_ctr("sw_end", 3, 13);

    run_branch(4'd11, 2'b00, 1'b1, "beq_eq");
    run_branch(4'd11, 2'b01, 1'b0, "beq_lt");
    run_branch(4'd13, 2'b01, 1'b1, "blt_lt");
    run_branch(4'd12, 2'b10, 1'b1, "bne_gt");
    run_branch(4'd12, 2'b00, 1'b0, "bne_eq");
    chk_ctr("br_end", 8, 28);
    chk("w_br_instret", 32'(w_instret), 0);
    chk("w_br_cycles", 32'(w_cycles), 4);

    // JMP
    op = 4'd14;
    step();
    step();
    chk("jmp_state", 32'(state), 9);
    chk("jmp_nbits", 32'(numBits), 2);
    chk("jmp_pcwe", 32'(PCWriteEnable), 1);
    chk("jmp_pcsrc", 32'(PCSource), 1);
    step();

    // LI
    op = 4'd8;
    step();
    step();
    chk("li_state", 32'(state), 10);
    chk("li_rdw", 32'(regDataWrite), 2);
    chk("li_we", 32'(writeEnable), 1);
    chk("li_nbits", 32'(numBits), 1);
    step();

    // ADDI
    op = 4'd7;
    step();
    step();
    chk("addi_state", 32'(state), 2);
    chk("addi_srcb", 32'(ALUSrcB), 1);
    chk("addi_aluop", 32'(ALUOp), 0);
    chk("addi_nbits", 32'(numBits), 0);
    step();
    step();
    chk_ctr("addi_end", 11, 38);

    // HALT
    op = 4'd15;
    step();
    step();
    chk("halt_state", 32'(state), 12);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_hold", 32'(halted), 1);
    end
    chk("halt_state_hold", 32'(state), 12);
    chk_ctr("halt_end", 11, 60);
    reset = 1'b1;
    #1;
    chk("halt_rst_halted", 32'(halted), 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_halt_state", 32'(state), 0);
    chk_ctr("post_halt", 0, 0);

    // Abort in MEM_WR
    op = 4'd10;
    step();
    step();
    step();
    chk("abort_pre_wr", 32'(memEnableWrite), 1);
    reset = 1'b1;
    #1;
    chk("abort_wr", 32'(memEnableWrite), 0);
    chk("abort_dors", 32'(DOrS), 0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state), 0);
    chk("abort_irwrite", 32'(IRWrite), 1);
    chk_ctr("abort", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
